led_scan_driver: RTL and testbench
==================================

// Module: led_scan_driver
// PURPOSE
//   Time-multiplexed N-digit 7-segment hex display driver. It captures a packed hex value and
//   per-digit decimal points, and applies them only at frame boundaries, so the display never
//   tears. It scans one digit at a time through a shared segment bus with a one-hot digit
//   select. It also provides all digits decoded in parallel, for boards with static displays.
// PARAMETERS
//   NUM_DIGITS  4     number of hex digits; must be >= 1
//   SCAN_DIV    1000  clock cycles each digit stays selected; must be >= 1
// PORTS
//   clk        in   1               sole clock; all state updates on the rising edge
//   rst        in   1               reset, synchronous, active-high
//   value      in   4*NUM_DIGITS    packed hex value; digit i = value[4i+3:4i], digit 0 rightmost
//   dp         in   NUM_DIGITS      decimal point per digit
//   load       in   1               1-cycle strobe; captures value and dp
//   blank      in   1               level input; forces all segments and selects off
//   seg_out    out  8               {a,b,c,d,e,f,g,dp}, active-high, a is the MSB
//   digit_sel  out  NUM_DIGITS      one-hot active-high digit enable
//   par_out    out  8*NUM_DIGITS    all digits decoded; digit i occupies bits [8i+7:8i]
//   frame_tick out  1               1-cycle pulse at every frame wrap
// BEHAVIOUR
//   Font (abcdefg_dp): 0=11111100 1=01100000 2=11011010 3=11110010 4=01100110 5=10110110
//     6=10111110 7=11100000 8=11111110 9=11110110 A=11101110 b=00111110 c=00011010
//     d=01111010 E=10011110 F=10001110; the dp bit is OR'd into bit 0.
//   State: pre (0..SCAN_DIV-1), idx (0..NUM_DIGITS-1), hold/shadow registers, pending, FSM.
//   FSM states:
//     IDLE (after reset): outputs dark; the first pending or load moves the FSM to SCAN
//       on that cycle, with a transfer.
//     SCAN: never leaves SCAN except on rst.
//   load: hold <= {value,dp}, pending <= 1. Several loads within one frame: the last one wins.
//   In SCAN, pre increments every cycle. When pre == SCAN_DIV-1: pre <= 0 and idx <= idx+1;
//     idx wraps from NUM_DIGITS-1 to 0.
//   Frame wrap (pre terminal and idx == NUM_DIGITS-1):
//     - frame_tick = 1 for that cycle.
//     - If pending, shadow <= hold and pending <= 0.
//   load on the transfer cycle: the inputs presented that cycle go straight to shadow,
//     and pending ends at 0.
//   Outputs are registered with 1-cycle latency from idx/shadow:
//     - digit_sel = 1<<idx
//     - seg_out = font(shadow digit idx)
//   par_out is updated 1 cycle after each transfer.
//   blank = 1: seg_out and digit_sel are 0 from the next cycle on; pre, idx and transfers keep
//     running. Deassertion resumes at the current idx. blank does not affect par_out.
//   NUM_DIGITS == 1: idx stays 0, and every pre terminal is a frame wrap.
//   rst, including mid-scan: every register is cleared.
//     - Outputs become seg_out=0, digit_sel=0, par_out=0, frame_tick=0.
//     - pre=0, idx=0, pending=0, FSM in IDLE.
//     - Any pending load is discarded.
// CONFIGURATION
//   LED_ZERO_SUPPRESS_EN defined:
//     - Leading zero digits (counting down from the MSB digit, stopping at the first non-zero
//       digit) have a font of 0, both on seg_out and in par_out.
//     - Digit 0 is never suppressed. A suppressed digit's dp still lights.
//     - digit_sel still scans the suppressed digits.
//   LED_ZERO_SUPPRESS_EN undefined: every digit is rendered, so zeros show 11111100.
// STRUCTURE
//   Package led_pkg holds:
//     - SEG_W = 8, the 16-entry font constant table, and function hex_font(nibble, dp).
//     - typedef scan_state_t {IDLE, SCAN}.
//   Sub-module led_hex_font: combinational nibble+dp -> 8-bit font. One instance feeds
//     seg_out; NUM_DIGITS instances (generate) feed par_out.
//   Top level holds pre/idx counters, hold/shadow/pending, FSM, and zero-suppress mask logic.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4 unless noted)
//   1. Reset: hold rst 3 cycles -> seg_out=0, digit_sel=0, par_out=0, frame_tick=0; stays
//      dark until the first load.
//   2. load value=16'h1A3F, dp=0 -> digit_sel steps 0001,0010,0100,1000, 4 cycles each;
//      seg_out F=10001110, 3=11110010, A=11101110, 1=01100000; par_out={1,A,3,F} fonts.
//   3. Mid-frame load 16'h0000 -> old digits are shown until frame_tick, then 11111100 on all
//      digits; two loads (h1111 then h2222) in one frame -> only 2 is displayed.
//   4. load on the frame-wrap cycle -> that value is shown from the very next frame;
//      frame_tick is exactly 1 cycle every 16 cycles.
//   5. blank high for 6 cycles mid-scan -> seg_out and digit_sel are 0 within 1 cycle; after
//      release, digit_sel matches the free-running idx (no restart); rst mid-scan -> IDLE, dark.
//   6. value=16'h0042, dp=4'b1000:
//      - with LED_ZERO_SUPPRESS_EN: digit3 seg=00000001, digit2 seg=0, digits 1 and 0 show 4 and 2.
//      - without it: digit3=11111101, digit2=11111100.
//      - value=0: with the macro only digit 0 shows 11111100.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and the 7-segment font for the hex scan driver.
// Font layout is {a,b,c,d,e,f,g,dp}, active-high, segment a in the MSB.
package led_pkg;

  localparam int SEG_W = 8;

  localparam logic [SEG_W-1:0] FONT_TBL [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  function automatic logic [SEG_W-1:0] hex_font(input logic [3:0] nibble, input logic dp);
    return FONT_TBL[nibble] | {{(SEG_W-1){1'b0}}, dp};
  endfunction

endpackage

// File: rtl/led_hex_font.sv
// Combinational nibble + decimal point to 7-segment pattern; zero latency, no flow control.
module led_hex_font
  import led_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             dp,
  output logic [SEG_W-1:0] seg
);

  assign seg = hex_font(nibble, dp);

endmodule

// File: rtl/led_scan_driver.sv
// Multiplexed N-digit hex display driver; new values apply only at frame wrap, outputs registered (1 cycle), no backpressure.
// Optional leading-zero blanking is enabled by defining LED_ZERO_SUPPRESS_EN.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*NUM_DIGITS-1:0]     value,
  input  logic [NUM_DIGITS-1:0]       dp,
  input  logic                        load,
  input  logic                        blank,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic [SEG_W*NUM_DIGITS-1:0] par_out,
  output logic                        frame_tick
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                 state_q, state_d;
  logic [PRE_W-1:0]            pre_q;
  logic [IDX_W-1:0]            idx_q;
  logic [4*NUM_DIGITS-1:0]     hold_val, shadow_val;
  logic [NUM_DIGITS-1:0]       hold_dp, shadow_dp;
  logic                        pending_q;

  logic                        pre_term, wrap, xfer;
  logic [NUM_DIGITS-1:0]       supp;
  logic [3:0]                  cur_nib;
  logic                        cur_dp, cur_sup;
  logic [NUM_DIGITS-1:0]       sel_d;
  logic [SEG_W-1:0]            scan_font, scan_seg;
  logic [SEG_W*NUM_DIGITS-1:0] par_d;

  assign pre_term   = (pre_q == PRE_LAST);
  assign wrap       = (state_q == SCAN) && pre_term && (idx_q == IDX_LAST);
  assign frame_tick = wrap;

  // A load arriving on the transfer cycle bypasses hold and lands in shadow directly.
  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load || pending_q) begin
          state_d = SCAN;
          xfer    = 1'b1;
        end
      end
      SCAN:    xfer    = wrap && (load || pending_q);
      default: state_d = IDLE;
    endcase
  end

`ifdef LED_ZERO_SUPPRESS_EN
  logic lead_zero;

  always_comb begin
    supp      = '0;
    lead_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead_zero = lead_zero && (shadow_val[4*i +: 4] == 4'h0);
      supp[i]   = lead_zero;
    end
  end
`else
  assign supp = '0;
`endif

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    sel_d   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib  = shadow_val[4*i +: 4];
        cur_dp   = shadow_dp[i];
        cur_sup  = supp[i];
        sel_d[i] = 1'b1;
      end
    end
  end

  led_hex_font u_scan_font (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (scan_font)
  );

  assign scan_seg = cur_sup ? {{(SEG_W-1){1'b0}}, cur_dp} : scan_font;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_par
    logic [SEG_W-1:0] font_g;

    led_hex_font u_font (
      .nibble (shadow_val[4*g +: 4]),
      .dp     (shadow_dp[g]),
      .seg    (font_g)
    );

    assign par_d[SEG_W*g +: SEG_W] = supp[g] ? {{(SEG_W-1){1'b0}}, shadow_dp[g]} : font_g;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      idx_q      <= '0;
      hold_val   <= '0;
      hold_dp    <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending_q  <= 1'b0;
      seg_out    <= '0;
      digit_sel  <= '0;
      par_out    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == SCAN) begin
        if (pre_term) begin
          pre_q <= '0;
          idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end

      if (load) begin
        hold_val <= value;
        hold_dp  <= dp;
      end

      if (xfer) begin
        pending_q  <= 1'b0;
        shadow_val <= load ? value : hold_val;
        shadow_dp  <= load ? dp    : hold_dp;
      end else if (load) begin
        pending_q  <= 1'b1;
      end

      // Blank only gates the scan bus; counters and transfers keep running.
      if ((state_q == SCAN) && !blank) begin
        seg_out   <= scan_seg;
        digit_sel <= sel_d;
      end else begin
        seg_out   <= '0;
        digit_sel <= '0;
      end

      par_out <= (state_q == SCAN) ? par_d : '0;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver (4 digits, 4 cycles per digit); build with
// LED_ZERO_SUPPRESS_EN defined to cover leading-zero blanking.
module tb_led_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst, load, blank;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [7:0]  seg_out;
  logic [3:0]  digit_sel;
  logic [31:0] par_out;
  logic        frame_tick;

  led_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .blank      (blank),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel),
    .par_out    (par_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  d;
  } disp_t;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  d;
    logic [31:0] par;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: s is the position in the 16-cycle frame of the current sample.
  bit          idle_m;
  int          s;
  disp_t       cur, prev;
  bit          prev_dark;
  bit          prev_blank;
  disp_t       q[$];
  logic [31:0] par_smp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (frame pos %0d)", name, act, exp, s);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  function automatic logic [7:0] bfont(input logic [3:0] n);
    case (n)
      4'h0: return 8'b11111100;  4'h1: return 8'b01100000;
      4'h2: return 8'b11011010;  4'h3: return 8'b11110010;
      4'h4: return 8'b01100110;  4'h5: return 8'b10110110;
      4'h6: return 8'b10111110;  4'h7: return 8'b11100000;
      4'h8: return 8'b11111110;  4'h9: return 8'b11110110;
      4'hA: return 8'b11101110;  4'hB: return 8'b00111110;
      4'hC: return 8'b00011010;  4'hD: return 8'b01111010;
      4'hE: return 8'b10011110;  default: return 8'b10001110;
    endcase
  endfunction

  function automatic logic [7:0] exp_digit(input disp_t x, input int i);
    logic [7:0] f;
    f = bfont(x.v[4*i +: 4]) | {7'b0, x.d[i]};
`ifdef LED_ZERO_SUPPRESS_EN
    begin
      bit z = 1'b1;
      for (int j = ND - 1; j >= i; j--)
        if (x.v[4*j +: 4] != 4'h0) z = 1'b0;
      if (i > 0 && z) f = {7'b0, x.d[i]};
    end
`endif
    return f;
  endfunction

  function automatic logic [31:0] par_of(input disp_t x);
    logic [31:0] p;
    for (int i = 0; i < ND; i++) p[8*i +: 8] = exp_digit(x, i);
    return p;
  endfunction

  // One clock cycle: sample and compare at the falling edge, then drive the next inputs.
  task automatic cyc(input logic r, input logic ld, input logic [15:0] v,
                     input logic [3:0] d, input logic bl);
    logic [7:0]  eseg;
    logic [3:0]  esel;
    logic [31:0] epar;
    logic        etick;
    int          dig;
    bit          dark;
    disp_t       src;
    @(negedge clk);
    par_smp = par_out;
    if (idle_m) begin
      eseg = '0; esel = '0; epar = '0; etick = 1'b0;
    end else begin
      s     = (s + 1) % 16;
      etick = (s == 0);
      if (s == 0) begin
        dig = 3; src = cur; dark = 1'b0;
      end else if (s == 1) begin
        dig = 3; src = prev; dark = prev_dark;
      end else begin
        dig = (s - 2) / 4; src = cur; dark = 1'b0;
      end
      epar = dark ? 32'h0 : par_of(src);
      esel = (dark || prev_blank) ? 4'h0 : 4'(1 << dig);
      eseg = (dark || prev_blank) ? 8'h0 : exp_digit(src, dig);
    end
    check("seg_out",    32'(seg_out),    32'(eseg));
    check("digit_sel",  32'(digit_sel),  32'(esel));
    check("par_out",    par_out,         epar);
    check("frame_tick", 32'(frame_tick), 32'(etick));

    rst = r; load = ld; value = v; dp = d; blank = bl;
    prev_blank = bl;
    if (r) begin
      idle_m = 1'b1;
      q.delete();
    end else if (idle_m) begin
      if (ld) begin
        idle_m = 1'b0; s = 0; prev_dark = 1'b1; cur = disp_t'({v, d});
      end
    end else begin
      if (ld) begin
        if (q.size() > 0) q[q.size()-1] = disp_t'({v, d});
        else q.push_back(disp_t'({v, d}));
      end
      if (s == 0) begin
        prev = cur; prev_dark = 1'b0;
        if (q.size() > 0) cur = q.pop_front();
      end
    end
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic wait_s(input int target);
    int g = 0;
    while ((idle_m || s != target) && g < 64) begin
      idle_cyc();
      g++;
    end
    if (g >= 64) timeout("wait_s");
  endtask

  task automatic run_par(input string name, input logic [31:0] expp);
    bit done = 1'b0;
    for (int k = 0; k < 24 && !done; k++) begin
      idle_cyc();
      if (!idle_m && s == 2) begin
        check(name, par_smp, expp);
        done = 1'b1;
      end
    end
    if (!done) timeout(name);
    repeat (8) idle_cyc();
  endtask

  vec_t vecs[5];

  initial begin
    rst = 1'b1; load = 1'b0; blank = 1'b0; value = '0; dp = '0;
    idle_m = 1'b1; s = 0; prev_dark = 1'b1; prev_blank = 1'b0; cur = '0; prev = '0;

    vecs[0] = '{16'h1A3F, 4'b0000, 32'h60EEF28E};
    vecs[3] = '{16'h8765, 4'b0101, 32'hFEE1BEB7};
`ifdef LED_ZERO_SUPPRESS_EN
    vecs[1] = '{16'h0000, 4'b0000, 32'h000000FC};
    vecs[2] = '{16'h0042, 4'b1000, 32'h010066DA};
    vecs[4] = '{16'h0B0C, 4'b0000, 32'h003EFC1A};
`else
    vecs[1] = '{16'h0000, 4'b0000, 32'hFCFCFCFC};
    vecs[2] = '{16'h0042, 4'b1000, 32'hFDFC66DA};
    vecs[4] = '{16'h0B0C, 4'b0000, 32'hFC3EFC1A};
`endif

    @(posedge clk);
    repeat (3) cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    repeat (6) idle_cyc();

    // Table: load mid-frame, expect the new value exactly from the following frame.
    for (int k = 0; k < 5; k++) begin
      if (!idle_m) wait_s(5);
      cyc(1'b0, 1'b1, vecs[k].v, vecs[k].d, 1'b0);
      run_par("par_vec", vecs[k].par);
    end

    // Two loads in one frame: only the later one is displayed.
    wait_s(3);
    cyc(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
    repeat (3) idle_cyc();
    cyc(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
    run_par("par_last_wins", 32'hDADADADA);

    // Load exactly on the frame-wrap cycle.
    wait_s(15);
    cyc(1'b0, 1'b1, 16'h9ED0, 4'h0, 1'b0);
    run_par("par_wrap_load", 32'hF69E7AFC);

    // Blank mid-scan for 6 cycles; scanning resumes at the free-running position.
    wait_s(5);
    repeat (6) cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    repeat (20) idle_cyc();

    // Reset mid-scan, pending load discarded, dark until the next load.
    wait_s(9);
    cyc(1'b0, 1'b1, 16'h5555, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    repeat (20) idle_cyc();
    cyc(1'b0, 1'b1, vecs[2].v, vecs[2].d, 1'b0);
    run_par("par_after_rst", vecs[2].par);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
